vote_tally: RTL and testbench
=============================

VOTE_TALLY -- requirements
Module: vote_tally

Interface
REQ-001 Parameter CNT_W, default 8, width of each per-candidate tally.
REQ-002 Parameter LOCKOUT, default 16, idle cycles enforced after each accepted vote (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mode  input  1  0 = voting, 1 = result display.
REQ-006 vote_logged  input  1  one-cycle debounced-press pulse from the upstream button stage.
REQ-007 candidate  input  4  candidate buttons, one bit per candidate, bit i = candidate i.
REQ-008 vote_ok  output  1  one-cycle pulse: vote counted.
REQ-009 vote_err  output  1  one-cycle pulse: vote rejected.
REQ-010 busy  output  1  high while in LOCK state.
REQ-011 result  output  CNT_W  tally of the selected candidate in display mode.
REQ-012 result_valid  output  1  result holds a legal selection.
REQ-013 total  output  CNT_W+2  sum of all four tallies.

Function
REQ-014 A legal candidate value has exactly one bit set; 0000 and multi-bit values are illegal.
REQ-015 State machine SHALL have states IDLE and LOCK; reset enters IDLE.
REQ-016 IDLE, vote_logged=1, mode=0, candidate legal -> increment that tally, pulse vote_ok next cycle, load lockout counter with LOCKOUT, go to LOCK.
REQ-017 IDLE, vote_logged=1, mode=0, candidate illegal -> no tally change, pulse vote_err next cycle, stay IDLE.
REQ-018 vote_logged=1 with mode=1 -> ignored silently: no tally change, no vote_ok/vote_err pulse.
REQ-019 LOCK: lockout counter decrements each cycle; vote_logged pulses are ignored, tallies unchanged, and vote_err pulses for each such pulse.
REQ-020 LOCK -> IDLE on the cycle the lockout counter reaches 0; busy is high exactly LOCKOUT cycles.
REQ-021 mode and candidate are sampled in the same cycle as vote_logged; a mode change in that cycle uses the new sampled value.
REQ-022 Tallies saturate at 2^CNT_W-1; a legal vote to a saturated candidate still pulses vote_ok, enters LOCK, and leaves the tally unchanged.
REQ-023 total SHALL equal the registered sum of the four tallies, zero-extended, updated the cycle after a tally changes.
REQ-024 mode=1, candidate legal -> result = that tally and result_valid=1, registered with 1-cycle latency.
REQ-025 mode=1 with candidate illegal, or mode=0 -> result=0, result_valid=0 (1-cycle latency).
REQ-026 Mode switching never alters tallies or the lockout counter.

Reset
REQ-027 reset low SHALL immediately clear all tallies, total, result, result_valid, vote_ok, vote_err, busy, and the lockout counter, and force IDLE.
REQ-028 Reset asserted mid-LOCK SHALL abort the lockout; first vote after reset release is accepted normally.
REQ-029 No state survives reset; there is no separate tally-clear input.

Structure
REQ-030 Shared package vote_pkg SHALL hold NUM_CAND=4, default CNT_W, default LOCKOUT, and the IDLE/LOCK state encoding.
REQ-031 A sub-module sat_counter (CNT_W-wide saturating incrementer with async active-low reset, inc enable) SHALL be instantiated once per candidate.
REQ-032 vote_tally connects directly downstream of the button-press stage; vote_logged, candidate, and mode come from the same sources as that stage.

Verification
REQ-033 mode=0, candidate=0010, one vote_logged pulse -> tally1=1, vote_ok one cycle later, busy high 16 cycles, total=1.
REQ-034 candidate=0110, vote_logged pulse -> vote_err pulse, all tallies 0, busy stays 0.
REQ-035 Legal vote then second pulse 5 cycles later (in LOCK) -> second pulse gives vote_err, tally unchanged; pulse at cycle 17 accepted.
REQ-036 CNT_W=8, 256 legal votes to candidate 3 -> tally3=255, 256th still pulses vote_ok, total=255.
REQ-037 After votes 3/1/0/2, mode=1, candidate=0001 -> result=3, result_valid=1 next cycle; candidate=0000 -> result=0, result_valid=0.
REQ-038 reset asserted 4 cycles into LOCK -> busy and all outputs 0 immediately, no clock edge needed; next legal vote counted.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared constants, FSM encoding and candidate-decode helpers for the vote tally block.
package vote_pkg;

  localparam int unsigned NUM_CAND    = 4;
  localparam int unsigned IDX_W       = $clog2(NUM_CAND);
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned DEF_LOCKOUT = 16;
  localparam int unsigned LOCK_W      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // A selection is legal only when exactly one candidate button is set.
  function automatic logic is_legal(input logic [NUM_CAND-1:0] cand);
    return ($countones(cand) == 1);
  endfunction

  function automatic logic [IDX_W-1:0] cand_idx(input logic [NUM_CAND-1:0] cand);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (cand[i]) idx = i[IDX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i, holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/vote_tally.sv
// Four-candidate vote counter with post-vote lockout, running total and display readout.
module vote_tally
  import vote_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned LOCKOUT = DEF_LOCKOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                vote_logged,
  input  logic [NUM_CAND-1:0] candidate,
  output logic                vote_ok,
  output logic                vote_err,
  output logic                busy,
  output logic [CNT_W-1:0]    result,
  output logic                result_valid,
  output logic [CNT_W+1:0]    total
);

  localparam int unsigned     TOT_W     = CNT_W + 2;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT);

  state_t             state_q;
  logic [LOCK_W-1:0]  lock_q;
  logic               vote_ok_q, vote_err_q;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic [TOT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   tally [NUM_CAND];
  logic               legal, accept;

  assign legal  = is_legal(candidate);
  assign accept = (state_q == IDLE) && vote_logged && !mode && legal;

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (clk),
      .rst_ni  (reset),
      .inc_i   (accept && candidate[g]),
      .count_o (tally[g])
    );
  end

  // Presses in display mode are dropped silently in either state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lock_q     <= '0;
      vote_ok_q  <= 1'b0;
      vote_err_q <= 1'b0;
    end else begin
      vote_ok_q  <= 1'b0;
      vote_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vote_logged && !mode) begin
            if (legal) begin
              vote_ok_q <= 1'b1;
              lock_q    <= LOCK_LOAD;
              state_q   <= LOCK;
            end else begin
              vote_err_q <= 1'b1;
            end
          end
        end
        LOCK: begin
          if (vote_logged && !mode) vote_err_q <= 1'b1;
          lock_q <= lock_q - LOCK_W'(1);
          if (lock_q == LOCK_W'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    total_d = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      total_d = total_d + TOT_W'(tally[i]);
    end
  end

  always_comb begin
    result_d = '0;
    valid_d  = 1'b0;
    if (mode && legal) begin
      result_d = tally[cand_idx(candidate)];
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      total_q  <= total_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign vote_ok      = vote_ok_q;
  assign vote_err     = vote_err_q;
  assign busy         = (state_q == LOCK);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign total        = total_q;

endmodule

// File: tb/tb_vote_tally.sv
// Scoreboard bench for vote_tally: a behavioural model queues per-cycle expectations.
module tb_vote_tally;
  import vote_pkg::*;

  localparam int unsigned CW = 8;
  localparam int unsigned LK = 16;

  logic          clk = 1'b0;
  logic          reset, mode, vote_logged;
  logic [3:0]    candidate;
  logic          vote_ok, vote_err, busy, result_valid;
  logic [CW-1:0] result;
  logic [CW+1:0] total;

  typedef struct {
    logic ok;
    logic err;
    logic busy;
    int   total;
    int   result;
    logic rv;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          m_tally[4];
  int          m_lock;

  vote_tally #(.CNT_W(CW), .LOCKOUT(LK)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .vote_logged  (vote_logged),
    .candidate    (candidate),
    .vote_ok      (vote_ok),
    .vote_err     (vote_err),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .total        (total)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_tally[i]) m_tally[i] = 0;
    m_lock = 0;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check("vote_ok",      vote_ok,      e.ok);
    check("vote_err",     vote_err,     e.err);
    check("busy",         busy,         e.busy);
    check("total",        total,        e.total);
    check("result",       result,       e.result);
    check("result_valid", result_valid, e.rv);
  endtask

  // One clock of stimulus: predict outputs after the next rising edge, then compare.
  task automatic cycle(input logic md, input logic vl, input logic [3:0] cd);
    exp_t e;
    int   sum, idx;
    bit   lg;
    @(negedge clk);
    mode = md; vote_logged = vl; candidate = cd;
    lg  = ($countones(cd) == 1);
    idx = 0;
    for (int i = 0; i < 4; i++) if (cd[i]) idx = i;
    sum = 0;
    foreach (m_tally[i]) sum += m_tally[i];
    e.ok = 1'b0; e.err = 1'b0; e.total = sum;
    e.rv = md && lg;
    e.result = e.rv ? m_tally[idx] : 0;
    if (m_lock > 0) begin
      e.err = vl && !md;
      m_lock--;
    end else if (vl && !md) begin
      if (lg) begin
        e.ok = 1'b1;
        if (m_tally[idx] < (1 << CW) - 1) m_tally[idx]++;
        m_lock = LK;
      end else begin
        e.err = 1'b1;
      end
    end
    e.busy = (m_lock > 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 4'b0000);
  endtask

  task automatic vote(input logic [3:0] cd);
    cycle(1'b0, 1'b1, cd);
    idle(LK);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_busy",     busy,         1'b0);
    check("rst_vote_ok",  vote_ok,      1'b0);
    check("rst_vote_err", vote_err,     1'b0);
    check("rst_total",    total,        '0);
    check("rst_result",   result,       '0);
    check("rst_valid",    result_valid, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int nb;
    logic [3:0] rc;
    reset = 1'b1; mode = 1'b0; vote_logged = 1'b0; candidate = '0;
    model_reset();
    #1 reset = 1'b0;
    #2;
    check("init_busy",  busy,         1'b0);
    check("init_ok",    vote_ok,      1'b0);
    check("init_err",   vote_err,     1'b0);
    check("init_total", total,        '0);
    check("init_valid", result_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Single legal vote: busy length measured independently of the model.
    cycle(1'b0, 1'b1, 4'b0010);
    nb = busy ? 1 : 0;
    repeat (20) begin
      cycle(1'b0, 1'b0, 4'b0000);
      if (busy) nb++;
    end
    check("busy_len", nb, LK);
    check("total_one", total, 1);

    // Illegal selections.
    cycle(1'b0, 1'b1, 4'b0110);
    check("illegal_err", vote_err, 1'b1);
    cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b0, 1'b1, 4'b1111);
    idle(2);

    // Press during lockout, then an accepted press at cycle 17.
    cycle(1'b0, 1'b1, 4'b0001);
    idle(4);
    cycle(1'b0, 1'b1, 4'b0001);
    check("lock_err", vote_err, 1'b1);
    idle(11);
    cycle(1'b0, 1'b1, 4'b0001);
    check("cyc17_ok", vote_ok, 1'b1);
    idle(LK + 2);

    // Press in display mode is silent.
    cycle(1'b1, 1'b1, 4'b0100);
    idle(2);

    // Readout: c0=3, c1=1, c2=0, c3=2 after a fresh reset.
    pulse_reset();
    vote(4'b0001); vote(4'b0001); vote(4'b0001);
    vote(4'b0010);
    vote(4'b1000); vote(4'b1000);
    idle(2);
    cycle(1'b1, 1'b0, 4'b0001);
    check("disp_c0", result, 3);
    check("disp_c0_v", result_valid, 1'b1);
    cycle(1'b1, 1'b0, 4'b0000);
    check("disp_none", result, 0);
    check("disp_none_v", result_valid, 1'b0);
    cycle(1'b1, 1'b0, 4'b1000);
    cycle(1'b1, 1'b0, 4'b0100);
    check("total_six", total, 6);

    // Reset four cycles into a lockout, then a normal vote.
    cycle(1'b0, 1'b1, 4'b0100);
    idle(4);
    pulse_reset();
    cycle(1'b0, 1'b1, 4'b0100);
    check("post_rst_ok", vote_ok, 1'b1);
    idle(LK + 1);

    // Saturation of candidate 3.
    pulse_reset();
    repeat (256) vote(4'b1000);
    idle(1);
    check("sat_total", total, 255);
    cycle(1'b1, 1'b0, 4'b1000);
    check("sat_result", result, 255);
    cycle(1'b0, 1'b1, 4'b1000);
    check("sat_ok", vote_ok, 1'b1);
    idle(LK + 2);

    // Random mix of modes, selections and presses.
    pulse_reset();
    repeat (600) begin
      if ($urandom_range(0, 1) == 1) rc = 4'b0001 << $urandom_range(0, 3);
      else                           rc = 4'($urandom);
      cycle(($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), rc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
